// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
//
// Shared definitions for the AXI4-Lite lab blocks:
//   resp_t       - AXI response codes carried on bresp/rresp
//   PROT_DEFAULT - protection bits driven on awprot/arprot
//   WSTRB_ALL    - write strobe that enables every byte lane of a word
//   seq_state_e  - states of the write-then-read-back master sequencer
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;
    localparam logic [3:0] WSTRB_ALL    = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } seq_state_e;

endpackage

// File: rtl/axi_lite_seq_master.sv
// ---------------------------------------------------------------------------
// axi_lite_seq_master
//
// Self-contained AXI4-Lite master sequencer. A rising edge on init starts a
// sequence that writes NUM_TXN words (word i goes to address i*4 and carries
// DATA_BASE + i), then reads every word back and compares it with what was
// written. txn_done pulses for one cycle at the end; error is a sticky flag
// raised by any non-OKAY response or read-back mismatch and cleared by the
// next start. Only one AXI transaction is ever outstanding.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   init                        start request (0->1 edge while idle)
//   txn_done                    one-cycle completion pulse
//   error                       sticky failure flag
//   awaddr/awprot/awvalid       write-address channel out, awready in
//   wdata/wstrb/wvalid          write-data channel out, wready in
//   bresp/bvalid in, bready out write-response channel
//   araddr/arprot/arvalid       read-address channel out, arready in
//   rdata/rresp/rvalid in       read-data channel, rready out
// ---------------------------------------------------------------------------
module axi_lite_seq_master
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 32,
    parameter int                NUM_TXN   = 4,
    parameter logic [DATA_W-1:0] DATA_BASE = 32'hA5A5_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    output logic              txn_done,
    output logic              error,

    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,

    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,

    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,

    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    // One extra bit over what NUM_TXN-1 needs keeps idx+1 from overflowing
    // even at the last word.
    localparam int                IDX_W    = $clog2(NUM_TXN) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);

    seq_state_e       state;
    logic [IDX_W-1:0] idx;
    logic             init_q;

    // Byte address of word i; words are 32-bit so the index is shifted by two.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] i);
        return ADDR_W'({i, 2'b00});
    endfunction

    // Pattern written to (and expected back from) word i.
    function automatic logic [DATA_W-1:0] word_data(input logic [IDX_W-1:0] i);
        return DATA_BASE + DATA_W'(i);
    endfunction

    assign awprot = PROT_DEFAULT;
    assign arprot = PROT_DEFAULT;

    // The whole sequencer lives in one clocked block so that every bus output
    // is a flop: valids and readies never depend combinationally on the
    // slave's signals. Each state both waits for its handshake and, when it
    // leaves, preloads the payload and valid of the state it enters, so a
    // ready-always slave costs one cycle per channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            init_q   <= 1'b0;
            txn_done <= 1'b0;
            error    <= 1'b0;
            awaddr   <= '0;
            awvalid  <= 1'b0;
            wdata    <= '0;
            wstrb    <= '0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            araddr   <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
        end else begin
            init_q   <= init;
            txn_done <= 1'b0;

            case (state)
                IDLE: begin
                    // Only a fresh 0->1 edge starts; holding init high does not
                    // retrigger because init_q is already 1 by the time we
                    // come back to IDLE.
                    if (init && !init_q) begin
                        state   <= WR_ADDR_DATA;
                        idx     <= '0;
                        error   <= 1'b0;
                        awaddr  <= word_addr('0);
                        wdata   <= word_data('0);
                        wstrb   <= WSTRB_ALL;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end
                end

                WR_ADDR_DATA: begin
                    // Both valids entered high together, so a low valid here
                    // means that channel's handshake already happened.
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        state  <= WR_RESP;
                        bready <= 1'b1;
                    end
                end

                WR_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (resp_t'(bresp) != OKAY) begin
                            error <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            idx     <= '0;
                            state   <= RD_ADDR;
                            araddr  <= word_addr('0);
                            arvalid <= 1'b1;
                        end else begin
                            idx     <= idx + 1'b1;
                            state   <= WR_ADDR_DATA;
                            awaddr  <= word_addr(idx + 1'b1);
                            wdata   <= word_data(idx + 1'b1);
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end
                    end
                end

                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (resp_t'(rresp) != OKAY || rdata != word_data(idx)) begin
                            error <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state    <= DONE;
                            txn_done <= 1'b1;
                        end else begin
                            idx     <= idx + 1'b1;
                            state   <= RD_ADDR;
                            araddr  <= word_addr(idx + 1'b1);
                            arvalid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // txn_done was raised on entry and the default above
                    // drops it again, giving exactly one cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_seq_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_seq_master
//
// Drives axi_lite_seq_master against a behavioural AXI-Lite slave that can
// stall each channel by a configurable number of cycles and inject bad
// write responses or corrupted read data on a chosen word. The expected bus
// traffic (address i*4, data DATA_BASE+i, in order) and the expected error
// outcome are computed from the sequence rules, not from the design.
// ---------------------------------------------------------------------------
module tb_axi_lite_seq_master;

    localparam int          ADDR_W    = 6;
    localparam int          DATA_W    = 32;
    localparam int          NUM_TXN   = 4;
    localparam logic [31:0] DATA_BASE = 32'hA5A5_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic              txn_done;
    logic              error;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    axi_lite_seq_master #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_TXN  (NUM_TXN),
        .DATA_BASE(DATA_BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .init    (init),
        .txn_done(txn_done),
        .error   (error),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Slave configuration, set by the main sequence while the bus is idle.
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int bresp_err_word = -1;
    int corrupt_word = -1;

    // Slave state.
    bit          have_aw = 0, have_w = 0, have_ar = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
    logic [5:0]  hs_awaddr = '0, hs_araddr = '0, lat_awaddr = '0, lat_araddr = '0;
    logic [31:0] hs_wdata = '0, lat_wdata = '0;
    logic [31:0] mem [NUM_TXN];
    int          seq_aw = 0, seq_w = 0, seq_ar = 0;

    // Observed traffic and completion record.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_err = 1'b0;
    int          start_cyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every txn_done cycle, with the error flag seen alongside it.
    always @(negedge clk) begin
        if (txn_done === 1'b1) begin
            done_cnt++;
            done_err = error;
            done_cyc = cyc;
        end
    end

    // Behavioural slave. Works on the falling edge: first retires the
    // handshakes that happened at the last rising edge, then checks what the
    // master is presenting now, then decides its own readies/valids and notes
    // which handshakes will happen at the coming rising edge.
    always @(negedge clk) begin
        if (reset) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
            arready = 0; rvalid = 0; rresp = 2'b00; rdata = '0;
            have_aw = 0; have_w = 0; have_ar = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
            seq_aw = 0; seq_w = 0; seq_ar = 0;
        end else begin
            if (hs_aw) begin
                have_aw = 1; lat_awaddr = hs_awaddr;
                wr_addr_q.push_back(32'(hs_awaddr)); seq_aw++;
            end
            if (hs_w) begin
                have_w = 1; lat_wdata = hs_wdata;
                wr_data_q.push_back(hs_wdata); seq_w++;
            end
            if (hs_b) begin
                bvalid = 0; have_aw = 0; have_w = 0; b_cnt = 0;
            end
            if (hs_ar) begin
                have_ar = 1; lat_araddr = hs_araddr;
                rd_addr_q.push_back(32'(hs_araddr)); seq_ar++;
            end
            if (hs_r) begin
                rvalid = 0; have_ar = 0; r_cnt = 0;
            end

            if (awvalid) begin
                checkOutput("awaddr", 32'(awaddr), 32'((seq_aw % NUM_TXN) * 4));
                checkOutput("aw_reissue", 32'(have_aw), 32'd0);
                checkOutput("awprot", 32'(awprot), 32'd0);
            end
            if (wvalid) begin
                checkOutput("wdata", wdata, DATA_BASE + 32'(seq_w % NUM_TXN));
                checkOutput("wstrb", 32'(wstrb), 32'hF);
                checkOutput("w_reissue", 32'(have_w), 32'd0);
            end
            if (bready) begin
                checkOutput("bready_early", 32'(have_aw && have_w), 32'd1);
            end
            if (arvalid) begin
                checkOutput("araddr", 32'(araddr), 32'((seq_ar % NUM_TXN) * 4));
                checkOutput("ar_outstanding", 32'(have_ar || have_aw || have_w), 32'd0);
                checkOutput("arprot", 32'(arprot), 32'd0);
            end
            if (rready) begin
                checkOutput("rready_early", 32'(have_ar), 32'd1);
            end

            if (awvalid && !have_aw) begin
                if (aw_cnt >= aw_delay) awready = 1;
                else begin awready = 0; aw_cnt++; end
            end else begin
                awready = 0; aw_cnt = 0;
            end
            if (wvalid && !have_w) begin
                if (w_cnt >= w_delay) wready = 1;
                else begin wready = 0; w_cnt++; end
            end else begin
                wready = 0; w_cnt = 0;
            end
            if (have_aw && have_w && !bvalid) begin
                if (b_cnt >= b_delay) begin
                    int word;
                    word = int'(lat_awaddr >> 2);
                    if (word < NUM_TXN) mem[word] = lat_wdata;
                    bresp  = (word == bresp_err_word) ? 2'b10 : 2'b00;
                    bvalid = 1;
                end else b_cnt++;
            end
            if (arvalid && !have_ar) begin
                if (ar_cnt >= ar_delay) arready = 1;
                else begin arready = 0; ar_cnt++; end
            end else begin
                arready = 0; ar_cnt = 0;
            end
            if (have_ar && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    int word;
                    word   = int'(lat_araddr >> 2);
                    rdata  = (word == corrupt_word || word >= NUM_TXN) ? 32'h0 : mem[word];
                    rresp  = 2'b00;
                    rvalid = 1;
                end else r_cnt++;
            end

            hs_aw = awvalid && awready; hs_awaddr = awaddr;
            hs_w  = wvalid && wready;   hs_wdata  = wdata;
            hs_b  = bvalid && bready;
            hs_ar = arvalid && arready; hs_araddr = araddr;
            hs_r  = rvalid && rready;
        end
    end

    // Raise init for hold cycles starting at a falling edge.
    task automatic applyStimulus(input int hold);
        @(negedge clk);
        init = 1'b1;
        start_cyc = cyc + 1;
        repeat (hold) @(negedge clk);
        init = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("txn_done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    // Reference: word i written to i*4 with DATA_BASE+i, then read from i*4.
    task automatic check_sequence(input logic exp_err);
        checkOutput("write_count", 32'(wr_addr_q.size()), 32'(NUM_TXN));
        checkOutput("wdata_count", 32'(wr_data_q.size()), 32'(NUM_TXN));
        checkOutput("read_count", 32'(rd_addr_q.size()), 32'(NUM_TXN));
        for (int i = 0; i < NUM_TXN; i++) begin
            if (i < wr_addr_q.size()) checkOutput("wr_addr_order", wr_addr_q[i], 32'(i * 4));
            if (i < wr_data_q.size()) checkOutput("wr_data_order", wr_data_q[i], DATA_BASE + 32'(i));
            if (i < rd_addr_q.size()) checkOutput("rd_addr_order", rd_addr_q[i], 32'(i * 4));
        end
        checkOutput("error_at_done", 32'(done_err), 32'(exp_err));
    endtask

    task automatic set_slave(input int aw, input int w, input int b, input int ar,
                             input int r, input int berr, input int corr);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
        bresp_err_word = berr; corrupt_word = corr;
    endtask

    task automatic run_sequence(input int hold, input logic exp_err, input bit check_cleared);
        int target;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        target = done_cnt + 1;
        applyStimulus(hold);
        if (check_cleared) checkOutput("error_cleared_on_start", 32'(error), 32'd0);
        wait_done(target, 600);
        repeat (3) @(negedge clk);
        check_sequence(exp_err);
        checkOutput("done_once", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int target;
        int n;
        logic exp_err;

        reset = 1'b1;
        init  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_awvalid", 32'(awvalid), 0);
        checkOutput("rst_wvalid", 32'(wvalid), 0);
        checkOutput("rst_bready", 32'(bready), 0);
        checkOutput("rst_arvalid", 32'(arvalid), 0);
        checkOutput("rst_rready", 32'(rready), 0);
        checkOutput("rst_txn_done", 32'(txn_done), 0);
        checkOutput("rst_error", 32'(error), 0);
        checkOutput("rst_awaddr", 32'(awaddr), 0);
        checkOutput("rst_araddr", 32'(araddr), 0);
        checkOutput("rst_wdata", wdata, 0);
        checkOutput("rst_wstrb", 32'(wstrb), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] basic always-ready sequence");
        set_slave(0, 0, 0, 0, 0, -1, -1);
        run_sequence(1, 1'b0, 0);
        checkOutput("latency", 32'(done_cyc - start_cyc), 32'(4 * NUM_TXN));

        $display("[TB] SLVERR on word 2");
        set_slave(0, 0, 0, 0, 0, 2, -1);
        run_sequence(1, 1'b1, 0);
        repeat (5) @(negedge clk);
        checkOutput("error_sticky", 32'(error), 1);

        $display("[TB] awready delayed 3 cycles");
        set_slave(3, 0, 0, 0, 0, -1, -1);
        run_sequence(1, 1'b0, 1);

        $display("[TB] rdata of word 1 corrupted");
        set_slave(0, 0, 0, 0, 0, -1, 1);
        run_sequence(1, 1'b1, 0);

        $display("[TB] reset during RD_DATA");
        set_slave(0, 0, 0, 0, 2, 0, -1);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        target = done_cnt;
        applyStimulus(1);
        n = 0;
        while (!(rready === 1'b1 && rd_addr_q.size() >= 2) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_rd_data", 32'(rready), 1);
        checkOutput("error_before_reset", 32'(error), 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_awvalid", 32'(awvalid), 0);
        checkOutput("mid_rst_wvalid", 32'(wvalid), 0);
        checkOutput("mid_rst_bready", 32'(bready), 0);
        checkOutput("mid_rst_arvalid", 32'(arvalid), 0);
        checkOutput("mid_rst_rready", 32'(rready), 0);
        checkOutput("mid_rst_error", 32'(error), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("no_done_after_reset", 32'(done_cnt), 32'(target));
        set_slave(0, 0, 0, 0, 0, -1, -1);
        run_sequence(1, 1'b0, 0);

        $display("[TB] init held high for 40 cycles");
        target = done_cnt + 1;
        run_sequence(40, 1'b0, 0);
        repeat (20) @(negedge clk);
        checkOutput("single_start_held", 32'(done_cnt), 32'(target));

        $display("[TB] init pulse during WR_RESP");
        set_slave(0, 0, 3, 0, 0, -1, -1);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        target = done_cnt + 1;
        applyStimulus(1);
        n = 0;
        while (bready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bready_seen", 32'(bready), 1);
        applyStimulus(1);
        wait_done(target, 600);
        repeat (30) @(negedge clk);
        checkOutput("ignored_restart", 32'(done_cnt), 32'(target));
        checkOutput("ignored_restart_writes", 32'(wr_addr_q.size()), 32'(NUM_TXN));

        $display("[TB] randomized slave timing and faults");
        for (int k = 0; k < 8; k++) begin
            int berr;
            int corr;
            berr = int'($urandom_range(0, 2 * NUM_TXN));
            corr = int'($urandom_range(0, 2 * NUM_TXN));
            if (berr >= NUM_TXN) berr = -1;
            if (corr >= NUM_TXN) corr = -1;
            set_slave(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), berr, corr);
            exp_err = (berr >= 0) || (corr >= 0);
            run_sequence(int'($urandom_range(1, 3)), exp_err, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
